seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch/execute FSM with a memory handshake and an 8-entry jump-target table.
// Optional execution cycle counter port enabled by defining SEQ_CYCLE_CNT_EN.
module seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] instr_in,
  input  logic       mem_ack,
  input  logic       lut_we,
  input  logic [2:0] lut_addr,
  input  logic [9:0] lut_data,
  output logic [9:0] pc,
  output logic [8:0] ir,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       busy,
  output logic       done
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMemWait, StDone} state_e;

  state_e     state_q, state_d;
  logic [9:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic [9:0] lut_q [8];

  logic [2:0] opcode;
  logic       is_alu, is_load, is_store, is_halt;

  assign opcode   = ir_q[8:6];
  assign is_alu   = (opcode == 3'b000) || (opcode == 3'b010) || (opcode == 3'b110) ||
                    (opcode == 3'b001) || (opcode == 3'b111);
  assign is_load  = (opcode == 3'b011);
  assign is_store = (opcode == 3'b100);
  assign is_halt  = (ir_q == 9'h17F);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Jump reads see the pre-write value when a write hits the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_addr] <= lut_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_d    = instr_in;
        state_d = StExec;
      end
      StExec: begin
        if (is_alu) begin
          pc_d    = pc_q + 10'd1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          if (mem_ack) begin
            pc_d    = pc_q + 10'd1;
            state_d = StFetch;
          end else begin
            state_d = StMemWait;
          end
        end else if (is_halt) begin
          state_d = StDone;
        end else begin
          pc_d    = lut_q[{1'b0, ir_q[5:4]}];
          state_d = StFetch;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          pc_d    = pc_q + 10'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so reset drops them immediately.
  always_comb begin
    reg_we  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StFetch: busy = 1'b1;
      StExec: begin
        busy    = 1'b1;
        reg_we  = is_alu || (is_load && mem_ack);
        mem_req = is_load || is_store;
        mem_we  = is_store;
      end
      StMemWait: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_store;
        reg_we  = is_load && mem_ack;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign pc = pc_q;
  assign ir = ir_q;

`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (((state_q == StIdle) || (state_q == StDone)) && start) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl; ROM is modelled as a combinational array indexed by pc.
// Cycle counter checks are compiled in only when SEQ_CYCLE_CNT_EN is defined.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] instr_in;
  logic       mem_ack;
  logic       lut_we;
  logic [2:0] lut_addr;
  logic [9:0] lut_data;
  logic [9:0] pc;
  logic [8:0] ir;
  logic       reg_we, mem_req, mem_we, busy, done;
`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  logic [8:0] rom [1024];
  int n_checks = 0;
  int n_fail   = 0;

  assign instr_in = rom[pc];

  always #5 clk = ~clk;

  seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .instr_in (instr_in),
    .mem_ack  (mem_ack),
    .lut_we   (lut_we),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .pc       (pc),
    .ir       (ir),
    .reg_we   (reg_we),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done)
`ifdef SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic lut_write(input logic [2:0] a, input logic [9:0] d);
    lut_we   = 1'b1;
    lut_addr = a;
    lut_data = d;
    step();
    lut_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h17F;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_ir", 32'(ir), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_req", 32'(mem_req), 32'h0);
    check_eq("rst_regwe", 32'(reg_we), 32'h0);
`ifdef SEQ_CYCLE_CNT_EN
    check_eq("rst_cnt", 32'(cycle_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // ALU op then halt
    rom[0] = 9'h040; rom[1] = 9'h17F;
    pulse_start();
    check_eq("a_fetch_busy", 32'(busy), 32'h1);
    check_eq("a_fetch_regwe", 32'(reg_we), 32'h0);
    step();
    check_eq("a_exec_ir", 32'(ir), 32'h040);
    check_eq("a_exec_regwe", 32'(reg_we), 32'h1);
    step();
    check_eq("a_fetch2_pc", 32'(pc), 32'h1);
    check_eq("a_fetch2_regwe", 32'(reg_we), 32'h0);
    step();
    check_eq("a_halt_regwe", 32'(reg_we), 32'h0);
    step();
    check_eq("a_done", 32'(done), 32'h1);
    check_eq("a_done_busy", 32'(busy), 32'h0);
    check_eq("a_done_pc", 32'(pc), 32'h1);
`ifdef SEQ_CYCLE_CNT_EN
    check_eq("a_cnt", 32'(cycle_cnt), 32'h4);
`endif

    // Load, ack on the fourth request cycle
    rom[0] = 9'h0C0;
    pulse_start();
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      check_eq("b_req", 32'(mem_req), 32'h1);
      check_eq("b_we", 32'(mem_we), 32'h0);
      check_eq("b_regwe", 32'(reg_we), (i == 3) ? 32'h1 : 32'h0);
      step();
      mem_ack = 1'b0;
    end
    #1;
    check_eq("b_after_req", 32'(mem_req), 32'h0);
    check_eq("b_after_pc", 32'(pc), 32'h1);
    check_eq("b_after_regwe", 32'(reg_we), 32'h0);
    step(); step();
    check_eq("b_done", 32'(done), 32'h1);

    // Store acked in EXEC: no MEMWAIT
    rom[0] = 9'h100;
    pulse_start();
    check_eq("c_fetch_req", 32'(mem_req), 32'h0);
    step();
    mem_ack = 1'b1;
    #1;
    check_eq("c_req", 32'(mem_req), 32'h1);
    check_eq("c_we", 32'(mem_we), 32'h1);
    check_eq("c_regwe", 32'(reg_we), 32'h0);
    step();
    mem_ack = 1'b0;
    #1;
    check_eq("c_after_req", 32'(mem_req), 32'h0);
    check_eq("c_after_we", 32'(mem_we), 32'h0);
    check_eq("c_after_regwe", 32'(reg_we), 32'h0);
    check_eq("c_after_pc", 32'(pc), 32'h1);
    step(); step();
    check_eq("c_done", 32'(done), 32'h1);

    // Jump through table entry 2
    lut_write(3'd2, 10'h155);
    rom[0] = 9'h160; rom[10'h155] = 9'h17F; rom[10'h2AA] = 9'h17F;
    pulse_start();
    step();
    check_eq("d_jmp_regwe", 32'(reg_we), 32'h0);
    check_eq("d_jmp_req", 32'(mem_req), 32'h0);
    step();
    check_eq("d_jmp_pc", 32'(pc), 32'h155);
    step(); step();
    check_eq("d_done_pc", 32'(pc), 32'h155);
    // Write to same entry in the jump's EXEC cycle: old target used
    pulse_start();
    step();
    lut_we = 1'b1; lut_addr = 3'd2; lut_data = 10'h2AA;
    step();
    lut_we = 1'b0;
    check_eq("d_old_pc", 32'(pc), 32'h155);
    step(); step();
    pulse_start();
    step(); step();
    check_eq("d_new_pc", 32'(pc), 32'h2AA);
    step(); step();
    check_eq("d_done2", 32'(done), 32'h1);

    // Pc wrap at 3FF, start ignored while busy
    lut_write(3'd3, 10'h3FF);
    rom[0] = 9'h170; rom[10'h3FF] = 9'h000;
    pulse_start();
    step(); step();
    check_eq("e_pc_3ff", 32'(pc), 32'h3FF);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("e_ign_ir", 32'(ir), 32'h000);
    check_eq("e_ign_regwe", 32'(reg_we), 32'h1);
    check_eq("e_ign_pc", 32'(pc), 32'h3FF);
    step();
    check_eq("e_wrap_pc", 32'(pc), 32'h000);
    check_eq("e_wrap_busy", 32'(busy), 32'h1);

    // Reset in MEMWAIT
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rom[0] = 9'h0C0;
    step();
    pulse_start();
    step(); step();
    check_eq("f_wait_req", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("f_rst_req", 32'(mem_req), 32'h0);
    check_eq("f_rst_busy", 32'(busy), 32'h0);
    check_eq("f_rst_pc", 32'(pc), 32'h0);
    check_eq("f_rst_ir", 32'(ir), 32'h0);
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("f_ack_busy", 32'(busy), 32'h0);
    check_eq("f_ack_req", 32'(mem_req), 32'h0);
    check_eq("f_ack_regwe", 32'(reg_we), 32'h0);
    check_eq("f_ack_pc", 32'(pc), 32'h0);
    check_eq("f_ack_done", 32'(done), 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
